// File: rtl/sgmii_link_pkg.sv
// rtl/sgmii_link_pkg.sv - shared state encoding and constants for the SGMII link sequencer
package sgmii_link_pkg;

  typedef enum logic [2:0] {
    ST_PHY_RST    = 3'd0,
    ST_PHY_SETTLE = 3'd1,
    ST_PCS_RST    = 3'd2,
    ST_AN_START   = 3'd3,
    ST_AN_WAIT    = 3'd4,
    ST_LINK_UP    = 3'd5,
    ST_FAULT      = 3'd6
  } link_state_e;

  localparam int          RETRY_W          = 3;
  localparam int          AN_START_CYCLES  = 4;
  localparam logic [4:0]  CONFIG_VECTOR    = 5'b10000;
  localparam logic [15:0] AN_CONFIG_VECTOR = 16'hD801;

  // Terminal count for a timed state; a zero-length request still lasts one cycle.
  function automatic int term_count(input int cycles);
    return (cycles < 1) ? 0 : cycles - 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sgmii_link_ctrl_if.sv
// rtl/sgmii_link_ctrl_if.sv - PHY/PCS control and status bundle of the link sequencer
interface sgmii_link_ctrl_if;
  import sgmii_link_pkg::*;

  logic                enable;
  logic [15:0]         status_vector;
  logic                phy_int_n;
  logic                phy_reset_n;
  logic                pcs_reset;
  logic [4:0]          config_vector;
  logic [15:0]         an_config_vector;
  logic                an_restart;
  logic                link_up;
  logic [RETRY_W-1:0]  retry_count;
  logic                fault;
  logic [2:0]          state_o;

  modport slave (
    input  enable, status_vector, phy_int_n,
    output phy_reset_n, pcs_reset, config_vector, an_config_vector,
           an_restart, link_up, retry_count, fault, state_o
  );

  modport master (
    output enable, status_vector, phy_int_n,
    input  phy_reset_n, pcs_reset, config_vector, an_config_vector,
           an_restart, link_up, retry_count, fault, state_o
  );
endinterface

// File: rtl/link_debounce.sv
// rtl/link_debounce.sv - level debouncer: output follows input only after it holds steady
module link_debounce #(
  parameter int DEB_CYCLES = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic stable_o
);
  import sgmii_link_pkg::*;

  localparam int            CNT_W = $clog2(max_int(DEB_CYCLES, 1)) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(term_count(DEB_CYCLES));

  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with the output discards the partial count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (level_i != stable_q) begin
      if (cnt_q == TERM) stable_d = level_i;
      else               cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/sgmii_link_ctrl.sv
// rtl/sgmii_link_ctrl.sv - SGMII PHY / PCS bring-up and link supervision sequencer
module sgmii_link_ctrl
  import sgmii_link_pkg::*;
#(
  parameter int PHY_RST_CYCLES    = 1250000,
  parameter int PHY_SETTLE_CYCLES = 625000,
  parameter int PCS_RST_CYCLES    = 16,
  parameter int AN_TIMEOUT_CYCLES = 125000000,
  parameter int LINK_DEB_CYCLES   = 1250,
  parameter int MAX_RETRIES       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  sgmii_link_ctrl_if.slave bus
);

  localparam int MAX_CYC = max_int(max_int(max_int(PHY_RST_CYCLES, PHY_SETTLE_CYCLES),
                                           max_int(PCS_RST_CYCLES, AN_TIMEOUT_CYCLES)),
                                   max_int(LINK_DEB_CYCLES, AN_START_CYCLES));
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]   T_PHY_RST    = CNT_W'(term_count(PHY_RST_CYCLES));
  localparam logic [CNT_W-1:0]   T_PHY_SETTLE = CNT_W'(term_count(PHY_SETTLE_CYCLES));
  localparam logic [CNT_W-1:0]   T_PCS_RST    = CNT_W'(term_count(PCS_RST_CYCLES));
  localparam logic [CNT_W-1:0]   T_AN_START   = CNT_W'(term_count(AN_START_CYCLES));
  localparam logic [CNT_W-1:0]   T_AN_TIMEOUT = CNT_W'(term_count(AN_TIMEOUT_CYCLES));
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  link_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic phy_reset_n_q, phy_reset_n_d;
  logic pcs_reset_q, pcs_reset_d;
  logic an_restart_q, an_restart_d;
  logic link_up_q, link_up_d;
  logic fault_q, fault_d;
  logic an_stable, link_stable;
  logic unused_status;

  assign unused_status = ^bus.status_vector[15:2];

  // Autoneg completion needs sync and link together; loss is judged on link_status alone.
  link_debounce #(.DEB_CYCLES(LINK_DEB_CYCLES)) u_deb_an (
    .clk      (clk),
    .rst_n    (rst_n),
    .level_i  (bus.status_vector[1] & bus.status_vector[0]),
    .stable_o (an_stable)
  );

  link_debounce #(.DEB_CYCLES(LINK_DEB_CYCLES)) u_deb_link (
    .clk      (clk),
    .rst_n    (rst_n),
    .level_i  (bus.status_vector[0]),
    .stable_o (link_stable)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      ST_PHY_RST:    if (cnt_q == T_PHY_RST)    state_d = ST_PHY_SETTLE;
      ST_PHY_SETTLE: if (cnt_q == T_PHY_SETTLE) state_d = ST_PCS_RST;
      ST_PCS_RST:    if (cnt_q == T_PCS_RST)    state_d = ST_AN_START;
      ST_AN_START:   if (cnt_q == T_AN_START)   state_d = ST_AN_WAIT;
      ST_AN_WAIT: begin
        if (an_stable) begin
          state_d = ST_LINK_UP;
          retry_d = '0;
        end else if (cnt_q == T_AN_TIMEOUT) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_AN_START;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      ST_LINK_UP:    if (!link_stable || !bus.phy_int_n) state_d = ST_AN_START;
      ST_FAULT:      state_d = ST_FAULT;
      default:       state_d = ST_PHY_RST;
    endcase

    // Dropping enable is the only way out of FAULT, and it also restarts the PHY.
    if (!bus.enable) begin
      state_d = ST_PHY_RST;
      retry_d = '0;
    end

    if (!bus.enable || (state_d != state_q) || (state_q == ST_LINK_UP) || (state_q == ST_FAULT))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    phy_reset_n_d = (state_d != ST_PHY_RST);
    pcs_reset_d   = (state_d == ST_PHY_RST) || (state_d == ST_PHY_SETTLE) || (state_d == ST_PCS_RST);
    an_restart_d  = (state_d == ST_AN_START);
    link_up_d     = (state_d == ST_LINK_UP);
    fault_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PHY_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      phy_reset_n_q <= 1'b0;
      pcs_reset_q   <= 1'b1;
      an_restart_q  <= 1'b0;
      link_up_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      phy_reset_n_q <= phy_reset_n_d;
      pcs_reset_q   <= pcs_reset_d;
      an_restart_q  <= an_restart_d;
      link_up_q     <= link_up_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.phy_reset_n      = phy_reset_n_q;
  assign bus.pcs_reset        = pcs_reset_q;
  assign bus.config_vector    = CONFIG_VECTOR;
  assign bus.an_config_vector = AN_CONFIG_VECTOR;
  assign bus.an_restart       = an_restart_q;
  assign bus.link_up          = link_up_q;
  assign bus.retry_count      = retry_q;
  assign bus.fault            = fault_q;
  assign bus.state_o          = state_q;

endmodule

// File: tb/tb_sgmii_link_ctrl.sv
// tb/tb_sgmii_link_ctrl.sv - directed table-driven bench for sgmii_link_ctrl
module tb_sgmii_link_ctrl;

  logic clk;
  logic rst_n;

  sgmii_link_ctrl_if sif();

  sgmii_link_ctrl #(
    .PHY_RST_CYCLES    (20),
    .PHY_SETTLE_CYCLES (10),
    .PCS_RST_CYCLES    (4),
    .AN_TIMEOUT_CYCLES (100),
    .LINK_DEB_CYCLES   (5),
    .MAX_RETRIES       (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         seq;
    int         cyc;
    logic       prn;
    logic       pcs;
    logic       anr;
    logic       lnk;
    logic       flt;
    logic [2:0] rty;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int seq, int cyc, logic prn, logic pcs, logic anr,
                              logic lnk, logic flt, logic [2:0] rty, logic [2:0] st);
    vec_t v;
    v.seq = seq; v.cyc = cyc; v.prn = prn; v.pcs = pcs; v.anr = anr;
    v.lnk = lnk; v.flt = flt; v.rty = rty; v.st = st;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rec(input vec_t v);
    string t;
    t = $sformatf("seq%0d_cyc%0d", v.seq, v.cyc);
    chk({t, "_phy_reset_n"}, int'(sif.phy_reset_n), int'(v.prn));
    chk({t, "_pcs_reset"},   int'(sif.pcs_reset),   int'(v.pcs));
    chk({t, "_an_restart"},  int'(sif.an_restart),  int'(v.anr));
    chk({t, "_link_up"},     int'(sif.link_up),     int'(v.lnk));
    chk({t, "_fault"},       int'(sif.fault),       int'(v.flt));
    chk({t, "_retry_count"}, int'(sif.retry_count), int'(v.rty));
    chk({t, "_state"},       int'(sif.state_o),     int'(v.st));
  endtask

  // Steps from cycle 0 (just after reset/enable release) through every record of one sequence.
  task automatic run_seq(input int seq);
    int c;
    c = 0;
    foreach (vecs[i]) begin
      if (vecs[i].seq == seq) begin
        while (c < vecs[i].cyc) begin
          step();
          c++;
        end
        check_rec(vecs[i]);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_phy_reset_n"}, int'(sif.phy_reset_n), 0);
    chk({tag, "_pcs_reset"},   int'(sif.pcs_reset),   1);
    chk({tag, "_an_restart"},  int'(sif.an_restart),  0);
    chk({tag, "_link_up"},     int'(sif.link_up),     0);
    chk({tag, "_fault"},       int'(sif.fault),       0);
    chk({tag, "_retry_count"}, int'(sif.retry_count), 0);
    chk({tag, "_state"},       int'(sif.state_o),     0);
  endtask

  task automatic wait_link(input string name);
    int n;
    n = 0;
    while (sif.link_up !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(name, int'(sif.link_up), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // bring-up from reset/enable: prn pcs anr lnk flt rty st
    vecs.push_back(mk(1,  1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 19, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 20, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 29, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 30, 1, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 33, 1, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 34, 1, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 37, 1, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 38, 1, 0, 0, 0, 0, 0, 4));
    // autoneg never completes: two retries then FAULT
    vecs.push_back(mk(2,  19, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2,  20, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2,  38, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(2, 137, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(2, 138, 1, 0, 1, 0, 0, 1, 3));
    vecs.push_back(mk(2, 141, 1, 0, 1, 0, 0, 1, 3));
    vecs.push_back(mk(2, 142, 1, 0, 0, 0, 0, 1, 4));
    vecs.push_back(mk(2, 241, 1, 0, 0, 0, 0, 1, 4));
    vecs.push_back(mk(2, 242, 1, 0, 1, 0, 0, 2, 3));
    vecs.push_back(mk(2, 246, 1, 0, 0, 0, 0, 2, 4));
    vecs.push_back(mk(2, 345, 1, 0, 0, 0, 0, 2, 4));
    vecs.push_back(mk(2, 346, 1, 0, 0, 0, 1, 2, 6));
    vecs.push_back(mk(2, 380, 1, 0, 0, 0, 1, 2, 6));

    rst_n = 1'b0;
    sif.enable = 1'b1;
    sif.status_vector = 16'h0000;
    sif.phy_int_n = 1'b1;
    step();
    step();
    check_reset_vals("reset");
    chk("config_vector",    int'(sif.config_vector),    'h10);
    chk("an_config_vector", int'(sif.an_config_vector), 'hD801);

    rst_n = 1'b1;
    run_seq(1);

    // Autoneg completes: link_up after 5 debounce cycles plus the output register.
    repeat (2) step();
    sif.status_vector = 16'h0003;
    repeat (5) step();
    chk("an_deb_before", int'(sif.link_up), 0);
    step();
    chk("an_deb_link_up", int'(sif.link_up), 1);
    chk("an_deb_state", int'(sif.state_o), 5);
    chk("an_deb_retry", int'(sif.retry_count), 0);

    // 3-cycle glitch is absorbed.
    sif.status_vector = 16'h0002;
    repeat (3) step();
    sif.status_vector = 16'h0003;
    repeat (8) step();
    chk("glitch3_link_up", int'(sif.link_up), 1);
    chk("glitch3_state", int'(sif.state_o), 5);

    // 6-cycle drop takes the link down.
    sif.status_vector = 16'h0002;
    repeat (5) step();
    chk("drop6_still_up", int'(sif.link_up), 1);
    step();
    chk("drop6_link_up", int'(sif.link_up), 0);
    chk("drop6_an_restart", int'(sif.an_restart), 1);
    chk("drop6_state", int'(sif.state_o), 3);
    chk("drop6_retry", int'(sif.retry_count), 0);
    sif.status_vector = 16'h0003;
    wait_link("relink_after_drop");

    // Single-cycle PHY interrupt.
    sif.phy_int_n = 1'b0;
    step();
    sif.phy_int_n = 1'b1;
    chk("phy_int_link_up", int'(sif.link_up), 0);
    chk("phy_int_state", int'(sif.state_o), 3);
    wait_link("relink_after_int");

    // enable=0 in LINK_UP forces PHY_RST and holds it.
    sif.enable = 1'b0;
    sif.status_vector = 16'h0000;
    step();
    check_reset_vals("enable_low");
    repeat (3) step();
    chk("enable_hold_state", int'(sif.state_o), 0);
    sif.enable = 1'b1;
    run_seq(2);

    // FAULT exits only through enable 0->1.
    sif.enable = 1'b0;
    step();
    check_reset_vals("fault_exit");
    sif.enable = 1'b1;
    repeat (50) step();
    chk("an_wait_before_rst", int'(sif.state_o), 4);

    // Asynchronous reset mid-AN_WAIT.
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    step();
    step();
    rst_n = 1'b1;
    run_seq(1);

    // Debounce completes on the very cycle the timeout expires: LINK_UP wins.
    repeat (94) step();
    sif.status_vector = 16'h0003;
    repeat (5) step();
    chk("tie_before_state", int'(sif.state_o), 4);
    step();
    chk("tie_state", int'(sif.state_o), 5);
    chk("tie_link_up", int'(sif.link_up), 1);
    chk("tie_retry", int'(sif.retry_count), 0);

    // Debounced loss and phy_int_n together: one restart, no retry counted.
    sif.status_vector = 16'h0002;
    repeat (5) step();
    chk("both_still_up", int'(sif.link_up), 1);
    sif.phy_int_n = 1'b0;
    step();
    sif.phy_int_n = 1'b1;
    sif.status_vector = 16'h0003;
    chk("both_state", int'(sif.state_o), 3);
    chk("both_an_restart", int'(sif.an_restart), 1);
    chk("both_retry", int'(sif.retry_count), 0);
    step();
    chk("both_single_state", int'(sif.state_o), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
